// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state, opcode and datapath select encodings for the multi-cycle RV32I core
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_LOAD   = 4'd3,
        S_LOADWB = 4'd4,
        S_STORE  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_HALT   = 4'd14,
        S_BAD    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR  = 2'd1;
    localparam logic [1:0] SRC_B_IMM   = 2'd2;

    localparam logic [1:0] ALU_ADD     = 2'd0;
    localparam logic [1:0] ALU_BRANCH  = 2'd1;
    localparam logic [1:0] ALU_FUNCT   = 2'd2;

    localparam logic [1:0] WB_ALUOUT   = 2'd0;
    localparam logic [1:0] WB_MDR      = 2'd1;
    localparam logic [1:0] WB_PC       = 2'd2;

    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main fetch/decode/execute/memory/writeback sequencer for the RV32I core
module multicycle_control
    import core_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       halt_o,
    output logic [3:0] state_o
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    assign state_o = rst_i ? 4'd0 : state;

    always_comb begin
        next_state  = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        iord_o      = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = PC_SRC_ALU;
        reg_write_o = 1'b0;
        wb_sel_o    = WB_ALUOUT;
        alu_src_a_o = SRC_A_PC;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_ADD;
        halt_o      = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_write_o  = 1'b1;
                    pc_write_o  = 1'b1;
                    alu_src_a_o = SRC_A_PC;
                    alu_src_b_o = SRC_B_FOUR;
                    next_state  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm here for branch/JAL targets
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                case (opcode_i)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                next_state  = (opcode_i == OP_LOAD) ? S_LOAD : S_STORE;
            end
            S_LOAD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ack_i) next_state = S_LOADWB;
            end
            S_LOADWB: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_MDR;
                next_state  = S_FETCH;
            end
            S_STORE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ack_i) next_state = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_op_o    = ALU_FUNCT;
                next_state  = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_FUNCT;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_ALUOUT;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_op_o    = ALU_BRANCH;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_write_o  = branch_taken_i;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                pc_write_o  = 1'b1;
                pc_src_o    = PC_SRC_ALUOUT;
                reg_write_o = 1'b1;
                wb_sel_o    = WB_PC;
                next_state  = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                pc_write_o  = 1'b1;
                pc_src_o    = PC_SRC_ALU;
                reg_write_o = 1'b1;
                wb_sel_o    = WB_PC;
                next_state  = S_FETCH;
            end
            S_LUI: begin
                alu_src_a_o = SRC_A_ZERO;
                alu_src_b_o = SRC_B_IMM;
                next_state  = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                next_state  = S_ALUWB;
            end
            S_HALT: begin
                halt_o     = 1'b1;
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset wins over everything, including an ack landing in the same cycle
        if (rst_i) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            reg_write_o = 1'b0;
            halt_o      = 1'b0;
            next_state  = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] opcode_i = 7'b0010011;
    logic       branch_taken_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o;
    logic       reg_write_o, halt_o;
    logic [1:0] wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ir_pulses;
    int cycles;

    always #5 clk_i = ~clk_i;

    multicycle_control dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .opcode_i       (opcode_i),
        .branch_taken_i (branch_taken_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .iord_o         (iord_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_src_o       (pc_src_o),
        .reg_write_o    (reg_write_o),
        .wb_sel_o       (wb_sel_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .halt_o         (halt_o),
        .state_o        (state_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check the state shown
    task automatic step(input logic ack, input logic taken, input logic rst,
                        input int exp_state, input string tag);
        @(negedge clk_i);
        mem_ack_i      = ack;
        branch_taken_i = taken;
        rst_i          = rst;
        #1;
        check({tag, "_state"}, int'(state_o), exp_state);
        if (ir_write_o) ir_pulses++;
    endtask

    initial begin
        // Reset with ack high: every strobe must stay low
        step(1'b1, 1'b0, 1'b1, 0, "rst");
        check("rst_mem_req", mem_req_o, 0);
        check("rst_ir_write", ir_write_o, 0);
        check("rst_pc_write", pc_write_o, 0);
        check("rst_halt", halt_o, 0);

        // ADDI, zero wait states: 0,1,7,8,0
        opcode_i = 7'b0010011;
        step(1'b1, 1'b0, 1'b0, 0, "addi_f");
        check("addi_f_mem_req", mem_req_o, 1);
        check("addi_f_pc_write", pc_write_o, 1);
        check("addi_f_src_b", alu_src_b_o, 1);
        check("addi_f_reg_write", reg_write_o, 0);
        step(1'b1, 1'b0, 1'b0, 1, "addi_d");
        check("addi_d_pc_write", pc_write_o, 0);
        check("addi_d_src_a", alu_src_a_o, 2);
        check("addi_d_src_b", alu_src_b_o, 2);
        check("addi_d_reg_write", reg_write_o, 0);
        step(1'b1, 1'b0, 1'b0, 7, "addi_e");
        check("addi_e_alu_op", alu_op_o, 2);
        check("addi_e_src_a", alu_src_a_o, 1);
        check("addi_e_pc_write", pc_write_o, 0);
        check("addi_e_reg_write", reg_write_o, 0);
        step(1'b1, 1'b0, 1'b0, 8, "addi_wb");
        check("addi_wb_reg_write", reg_write_o, 1);
        check("addi_wb_wb_sel", wb_sel_o, 0);
        check("addi_wb_pc_write", pc_write_o, 0);

        // LW with two wait cycles on fetch and load: 9 cycles total
        opcode_i = 7'b0000011;
        ir_pulses = 0;
        step(1'b0, 1'b0, 1'b0, 0, "lw_f0");
        check("lw_f0_ir_write", ir_write_o, 0);
        check("lw_f0_pc_write", pc_write_o, 0);
        step(1'b0, 1'b0, 1'b0, 0, "lw_f1");
        step(1'b1, 1'b0, 1'b0, 0, "lw_f2");
        step(1'b0, 1'b0, 1'b0, 1, "lw_d");
        step(1'b0, 1'b0, 1'b0, 2, "lw_ma");
        check("lw_ma_src_b", alu_src_b_o, 2);
        step(1'b0, 1'b0, 1'b0, 3, "lw_l0");
        check("lw_l0_mem_req", mem_req_o, 1);
        check("lw_l0_iord", iord_o, 1);
        check("lw_l0_mem_we", mem_we_o, 0);
        step(1'b0, 1'b0, 1'b0, 3, "lw_l1");
        check("lw_l1_mem_req", mem_req_o, 1);
        step(1'b1, 1'b0, 1'b0, 3, "lw_l2");
        step(1'b1, 1'b0, 1'b0, 4, "lw_wb");
        check("lw_wb_wb_sel", wb_sel_o, 1);
        check("lw_wb_reg_write", reg_write_o, 1);
        check("lw_ir_pulses", ir_pulses, 1);

        // BEQ taken then not taken
        opcode_i = 7'b1100011;
        step(1'b1, 1'b0, 1'b0, 0, "beqt_f");
        step(1'b1, 1'b0, 1'b0, 1, "beqt_d");
        step(1'b1, 1'b1, 1'b0, 9, "beqt_b");
        check("beqt_pc_write", pc_write_o, 1);
        check("beqt_pc_src", pc_src_o, 1);
        check("beqt_alu_op", alu_op_o, 1);
        step(1'b1, 1'b0, 1'b0, 0, "beqn_f");
        step(1'b1, 1'b0, 1'b0, 1, "beqn_d");
        step(1'b1, 1'b0, 1'b0, 9, "beqn_b");
        check("beqn_pc_write", pc_write_o, 0);

        // JALR
        opcode_i = 7'b1100111;
        step(1'b1, 1'b0, 1'b0, 0, "jalr_f");
        step(1'b1, 1'b0, 1'b0, 1, "jalr_d");
        step(1'b1, 1'b0, 1'b0, 11, "jalr_x");
        check("jalr_pc_write", pc_write_o, 1);
        check("jalr_pc_src", pc_src_o, 0);
        check("jalr_reg_write", reg_write_o, 1);
        check("jalr_wb_sel", wb_sel_o, 2);
        check("jalr_src_a", alu_src_a_o, 1);

        // JAL and LUI
        opcode_i = 7'b1101111;
        step(1'b1, 1'b0, 1'b0, 0, "jal_f");
        step(1'b1, 1'b0, 1'b0, 1, "jal_d");
        step(1'b1, 1'b0, 1'b0, 10, "jal_x");
        check("jal_pc_src", pc_src_o, 1);
        opcode_i = 7'b0110111;
        step(1'b1, 1'b0, 1'b0, 0, "lui_f");
        step(1'b1, 1'b0, 1'b0, 1, "lui_d");
        step(1'b1, 1'b0, 1'b0, 12, "lui_x");
        check("lui_src_a", alu_src_a_o, 3);
        step(1'b1, 1'b0, 1'b0, 8, "lui_wb");

        // Reset during STORE with ack high
        opcode_i = 7'b0100011;
        step(1'b1, 1'b0, 1'b0, 0, "sw_f");
        step(1'b1, 1'b0, 1'b0, 1, "sw_d");
        step(1'b0, 1'b0, 1'b0, 2, "sw_ma");
        step(1'b0, 1'b0, 1'b0, 5, "sw_s0");
        check("sw_s0_mem_we", mem_we_o, 1);
        check("sw_s0_mem_req", mem_req_o, 1);
        step(1'b1, 1'b0, 1'b1, 0, "sw_rst");
        check("sw_rst_mem_we", mem_we_o, 0);
        check("sw_rst_mem_req", mem_req_o, 0);
        check("sw_rst_reg_write", reg_write_o, 0);
        step(1'b0, 1'b0, 1'b0, 0, "sw_after");
        check("sw_after_mem_req", mem_req_o, 1);

        // CSR opcode traps into HALT and stays there
        opcode_i = 7'b1110011;
        step(1'b1, 1'b0, 1'b0, 0, "sys_f");
        step(1'b0, 1'b0, 1'b0, 1, "sys_d");
        step(1'b0, 1'b0, 1'b0, 14, "sys_h");
        check("sys_halt", halt_o, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'(i % 2), 1'b0, 1'b0, 14, "sys_hold");
            check("sys_hold_mem_req", mem_req_o, 0);
            check("sys_hold_pc_write", pc_write_o, 0);
        end
        step(1'b0, 1'b0, 1'b1, 0, "sys_rst");
        check("sys_rst_halt", halt_o, 0);
        step(1'b0, 1'b0, 1'b0, 0, "sys_after");
        check("sys_after_mem_req", mem_req_o, 1);

        // FETCH must wait out a long stall within a bounded budget
        opcode_i = 7'b0010011;
        cycles = 0;
        while (cycles < 5) begin
            step(1'b0, 1'b0, 1'b0, 0, "stall");
            cycles++;
        end
        step(1'b1, 1'b0, 1'b0, 0, "stall_ack");
        step(1'b0, 1'b0, 1'b0, 1, "stall_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
